// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bundle of the serializer: upstream valid/ready handshake
// plus the serial stream and status flags towards the pattern detector.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             out;
  logic             out_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, out, out_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, out, out_valid, word_done, busy
  );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: buffers up to two words (shifter + holding
// register) and streams them gap-free on out, one bit per clock.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic             clk,
  input logic             rst,
  seq_serializer_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hr;
  logic             hv;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             accept;
  logic             load_sr_din;
  logic             load_hr;

  function automatic logic [CW-1:0] bit_index(input logic [CW-1:0] c);
    return MSB_FIRST ? (LAST - c) : c;
  endfunction

  assign last_bit    = (state == SHIFT) && (cnt == LAST);
  assign accept      = bus.din_valid && !hv;
  // A word arriving on the last-bit edge with HR empty bypasses HR so the stream stays continuous.
  assign load_sr_din = accept && ((state == IDLE) || last_bit);
  assign load_hr     = accept && (state == SHIFT) && !last_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hv    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            cnt <= '0;
            if (hv) hv <= 1'b0;
            else if (!accept) state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (accept) hv <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data registers carry no reset; their contents are ignored while IDLE / hv=0.
  always_ff @(posedge clk) begin
    if (last_bit && hv) sr <= hr;
    else if (load_sr_din) sr <= bus.din;
    if (load_hr) hr <= bus.din;
  end

  assign bus.din_ready = !hv;
  assign bus.out_valid = (state == SHIFT);
  assign bus.out       = (state == SHIFT) ? sr[bit_index(cnt)] : IDLE_BIT;
  assign bus.word_done = last_bit;
  assign bus.busy      = (state == SHIFT) || hv;
endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: an MSB-first and an LSB-first instance
// share the same upstream stimulus; one of them is observed at a time.
module tb_seq_serializer;
  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       sel;
  int         n_chk;
  int         n_fail;

  seq_serializer_if #(.WIDTH(8)) ifm ();
  seq_serializer_if #(.WIDTH(8)) ifl ();

  assign ifm.din       = din;
  assign ifm.din_valid = din_valid;
  assign ifl.din       = din;
  assign ifl.din_valid = din_valid;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .bus(ifm)
  );
  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bus(ifl)
  );

  logic o_out, o_vld, o_done, o_busy, o_rdy;
  assign o_out  = sel ? ifl.out       : ifm.out;
  assign o_vld  = sel ? ifl.out_valid : ifm.out_valid;
  assign o_done = sel ? ifl.word_done : ifm.word_done;
  assign o_busy = sel ? ifl.busy      : ifm.busy;
  assign o_rdy  = sel ? ifl.din_ready : ifm.din_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // 11011 non-overlapping detector reference, walked over a captured stream (first bit at nb-1).
  function automatic int det_count(input logic [23:0] b, input int nb);
    int s    = 0;
    int hits = 0;
    for (int i = nb - 1; i >= 0; i--) begin
      case (s)
        0:       s = b[i] ? 1 : 0;
        1:       s = b[i] ? 2 : 0;
        2:       s = b[i] ? 2 : 3;
        3:       s = b[i] ? 4 : 0;
        default: begin
          if (b[i]) hits++;
          s = 0;
        end
      endcase
    end
    return hits;
  endfunction

  // Presents n words (words[23:16] first) with din_valid held, collects the serial stream.
  task automatic run_stream(input logic [23:0] words, input int n,
                            output logic [23:0] bits, output logic [23:0] dmask,
                            output int nb, output int rlow, output int gaps,
                            output int lat, output bit fin);
    int idx     = 0;
    int c_acc   = -1;
    int c_first = -1;
    bit started = 0;
    bit ended   = 0;
    bits = '0; dmask = '0; nb = 0; rlow = 0; gaps = 0; lat = -1; fin = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (o_vld) begin
        if (ended) gaps++;
        if (!started) c_first = c;
        started = 1;
        bits  = {bits[22:0], o_out};
        dmask = {dmask[22:0], o_done};
        nb++;
      end else if (started) begin
        ended = 1;
      end
      if (!o_rdy) rlow++;
      if (idx < n) begin
        din       = words[23 - 8*idx -: 8];
        din_valid = 1'b1;
        if (o_rdy) begin
          if (c_acc < 0) c_acc = c;
          idx++;
        end
      end else begin
        din_valid = 1'b0;
        din       = '0;
        if (started && !o_busy) fin = 1;
      end
    end
    lat = c_first - c_acc;
  endtask

  typedef struct packed {
    logic        sel;
    int          n;
    logic [23:0] words;
    logic [23:0] exp_bits;
    logic [23:0] exp_done;
    int          exp_nb;
    int          exp_rlow;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [23:0] bits, dmask;
    int          nb, rlow, gaps, lat, nvld, nbusy;
    bit          fin;

    n_chk = 0; n_fail = 0;
    sel = 1'b0; din = '0; din_valid = 1'b0; rst = 1'b0;

    vt[0] = '{1'b0, 1, 24'hD80000, 24'h0000D8, 24'h000001,  8,  0};
    vt[1] = '{1'b0, 2, 24'hA53C00, 24'h00A53C, 24'h000101, 16,  7};
    vt[2] = '{1'b0, 3, 24'hA53CF0, 24'hA53CF0, 24'h010101, 24, 14};
    vt[3] = '{1'b1, 1, 24'h1B0000, 24'h0000D8, 24'h000001,  8,  0};
    vt[4] = '{1'b1, 2, 24'h018000, 24'h008001, 24'h000101, 16,  7};
    vt[5] = '{1'b0, 1, 24'h000000, 24'h000000, 24'h000001,  8,  0};

    repeat (3) @(negedge clk);
    check("reset out_valid", o_vld, 0);
    check("reset out", o_out, 0);
    check("reset word_done", o_done, 0);
    check("reset busy", o_busy, 0);
    check("reset din_ready", o_rdy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      sel = vt[v].sel;
      run_stream(vt[v].words, vt[v].n, bits, dmask, nb, rlow, gaps, lat, fin);
      check($sformatf("v%0d finished", v), fin, 1);
      check($sformatf("v%0d bits", v), bits, vt[v].exp_bits);
      check($sformatf("v%0d bit count", v), nb, vt[v].exp_nb);
      check($sformatf("v%0d word_done mask", v), dmask, vt[v].exp_done);
      check($sformatf("v%0d din_ready low cycles", v), rlow, vt[v].exp_rlow);
      check($sformatf("v%0d gaps", v), gaps, 0);
      check($sformatf("v%0d latency", v), lat, 1);
      check($sformatf("v%0d idle out", v), o_out, 0);
      check($sformatf("v%0d idle din_ready", v), o_rdy, 1);
      check($sformatf("v%0d idle word_done", v), o_done, 0);
    end
    sel = 1'b0;

    // New word offered exactly on the last-bit edge with HR empty.
    @(negedge clk);
    din = 8'hD8; din_valid = 1'b1;
    bits = '0; rlow = 0; nvld = 0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      din_valid = 1'b0;
      if (o_vld) begin
        bits = {bits[22:0], o_out};
        nvld++;
      end
      if (!o_rdy) rlow++;
      if (c == 8 && o_done) begin
        din = 8'h5A; din_valid = 1'b1;
      end
    end
    check("bypass bits", bits, 24'h00D85A);
    check("bypass valid count", nvld, 16);
    check("bypass din_ready low", rlow, 0);
    check("bypass idle busy", o_busy, 0);

    // Detector integration over the serial stream.
    run_stream(24'h1B6000, 2, bits, dmask, nb, rlow, gaps, lat, fin);
    check("det1 bits", bits, 24'h001B60);
    check("det1 hits", det_count(bits, nb), 1);
    run_stream(24'hDEC000, 2, bits, dmask, nb, rlow, gaps, lat, fin);
    check("det2 bits", bits, 24'h00DEC0);
    check("det2 gaps", gaps, 0);
    check("det2 hits", det_count(bits, nb), 2);

    // Reset mid-word with HR full.
    @(negedge clk);
    din = 8'hFF; din_valid = 1'b1;
    @(negedge clk);
    din = 8'h0F; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("pre-reset busy", o_busy, 1);
    check("pre-reset din_ready", o_rdy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid reset out_valid", o_vld, 0);
    check("mid reset out", o_out, 0);
    check("mid reset busy", o_busy, 0);
    check("mid reset din_ready", o_rdy, 1);
    check("mid reset word_done", o_done, 0);
    @(negedge clk);
    rst = 1'b1;
    nvld = 0; nbusy = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_vld) nvld++;
      if (o_busy) nbusy++;
    end
    check("post reset valid cycles", nvld, 0);
    check("post reset busy cycles", nbusy, 0);
    run_stream(24'h960000, 1, bits, dmask, nb, rlow, gaps, lat, fin);
    check("post reset finished", fin, 1);
    check("post reset bits", bits, 24'h000096);
    check("post reset bit count", nb, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
